// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit that owns the MIPS HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over 32
// cycles, followed by a sign-fix/write-back cycle. MTHI/MTLO write directly.
// Optional macro HILO_FAST_MULT_EN: MULT/MULTU use a single-cycle combinational
// multiply and bypass the iterative phase; divide timing is unaffected.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  alu_control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, next_state;
    logic [4:0]  cnt;

    // Operand/iteration storage; only meaningful while an op is in flight.
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        op_div, div_zero, neg_q, neg_r;

    logic        is_mul, is_div, is_signed, accept;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [33:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Two's-complement magnitude of a 32-bit operand when treated as signed.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        logic signed [31:0] sx;
        sx = x;
        return (sgn && sx < 0) ? 32'(-sx) : x;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

`ifdef HILO_FAST_MULT_EN
    logic signed [63:0] fast_a, fast_b, fast_prod;
    assign fast_a    = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign fast_b    = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign fast_prod = fast_a * fast_b;
`endif

    // Decode and per-iteration datapath arithmetic.
    always_comb begin
        is_mul    = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
        is_div    = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
        is_signed = ~alu_control[0];
        accept    = start && (state == IDLE) && (is_mul || is_div);
        // Shift-add: conditionally add multiplicand to the upper half, shift right.
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        // Restoring divide: acc = {remainder, dividend bits shifting into quotient}.
        div_trial = {1'b0, acc[63:32], acc[31]} - {2'b00, opnd};
        div_next  = div_trial[33] ? {acc[62:31], acc[30:0], 1'b0}
                                  : {div_trial[31:0], acc[30:0], 1'b1};
        prod_fix  = neg64(acc, neg_q);
        quo_fix   = neg32(acc[31:0], neg_q);
        rem_fix   = neg32(acc[63:32], neg_r);
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_div && (b == 32'd0))
                        next_state = FIX;
`ifdef HILO_FAST_MULT_EN
                    else if (is_mul)
                        next_state = FIX;
`endif
                    else
                        next_state = CALC;
                end
            end
            CALC:    if (cnt == 5'd0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch at accept, then one multiply/divide step per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_div   <= is_div;
            div_zero <= is_div && (b == 32'd0);
            neg_r    <= is_signed && a[31];
            opnd     <= is_div ? mag32(b, is_signed) : mag32(a, is_signed);
`ifdef HILO_FAST_MULT_EN
            neg_q    <= is_div && is_signed && (a[31] ^ b[31]);
            acc      <= is_div ? {32'd0, mag32(a, is_signed)} : fast_prod;
`else
            neg_q    <= is_signed && (a[31] ^ b[31]);
            acc      <= is_div ? {32'd0, mag32(a, is_signed)} : {32'd0, mag32(b, is_signed)};
`endif
        end else if (state == CALC) begin
            acc <= op_div ? div_next : mul_next;
        end
    end

    // Control state, status pulses and the architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= 32'd0;
            lo_out      <= 32'd0;
        end else begin
            state       <= next_state;
            busy        <= (next_state != IDLE);
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && div_zero;
            if (state == CALC)
                cnt <= cnt - 5'd1;
            else if (next_state == CALC)
                cnt <= 5'd31;
            if (start && (state == IDLE)) begin
                if (alu_control == OP_MTLO) lo_out <= a;
                if (alu_control == OP_MTHI) hi_out <= a;
            end
            if ((state == FIX) && !div_zero) begin
                if (op_div) begin
                    hi_out <= rem_fix;
                    lo_out <= quo_fix;
                end else begin
                    hi_out <= prod_fix[63:32];
                    lo_out <= prod_fix[31:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed testbench for hilo_muldiv: multiply, divide, divide-by-zero,
// MTHI/MTLO, busy-ignore behaviour and mid-operation reset.
module tb_hilo_muldiv;

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

`ifdef HILO_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  alu_control = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int failures = 0;

    hilo_muldiv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle (cycle 0); returns #1 into cycle 1.
    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        alu_control = op;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        alu_control = 5'd0;
    endtask

    // Issue an op, check busy profile, and return #1 into the done cycle.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int lat);
        issue(op, x, y);
        check({tag, " busy_c1"}, {31'd0, busy}, 32'd1);
        if (lat > 2) begin
            repeat (lat - 2) @(posedge clk);
            #1;
            check({tag, " busy_last"}, {31'd0, busy}, 32'd1);
            check({tag, " done_early"}, {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst hi", hi_out, 32'd0);
        check("rst lo", lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULTU max * max
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        check("multu_max hi", hi_out, 32'hFFFF_FFFE);
        check("multu_max lo", lo_out, 32'h0000_0001);
        check("multu_max dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        check("multu_max done_pulse", {31'd0, done}, 32'd0);
        check("multu_max hi_hold", hi_out, 32'hFFFF_FFFE);

        // MULT -3 * 5
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, MUL_LAT);
        check("mult_neg hi", hi_out, 32'hFFFF_FFFF);
        check("mult_neg lo", lo_out, 32'hFFFF_FFF1);

        // DIV -7 / 2
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        check("div_neg lo", lo_out, 32'hFFFF_FFFD);
        check("div_neg hi", hi_out, 32'hFFFF_FFFF);

        // DIV overflow case
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        check("div_ovf lo", lo_out, 32'h8000_0000);
        check("div_ovf hi", hi_out, 32'h0000_0000);

        // MTHI / MTLO
        issue(OP_MTHI, 32'hAAAA_0000, 32'd0);
        check("mthi hi", hi_out, 32'hAAAA_0000);
        check("mthi done", {31'd0, done}, 32'd0);
        check("mthi busy", {31'd0, busy}, 32'd0);
        issue(OP_MTLO, 32'h0000_5555, 32'd0);
        check("mtlo lo", lo_out, 32'h0000_5555);
        check("mtlo hi", hi_out, 32'hAAAA_0000);

        // DIVU by zero
        run_op("divz", OP_DIVU, 32'd5, 32'd0, 2);
        check("divz dbz", {31'd0, div_by_zero}, 32'd1);
        check("divz hi", hi_out, 32'hAAAA_0000);
        check("divz lo", lo_out, 32'h0000_5555);
        @(posedge clk);
        #1;
        check("divz dbz_pulse", {31'd0, div_by_zero}, 32'd0);
        check("divz done_pulse", {31'd0, done}, 32'd0);

        // DIVU 100/7 with ignored MTHI and MULT at cycles 10 and 11
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        alu_control = OP_MTHI;
        a = 32'h0000_1234;
        @(posedge clk);
        #1;
        alu_control = OP_MULT;
        a = 32'd3;
        b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        alu_control = 5'd0;
        check("busy_ign hi", hi_out, 32'hAAAA_0000);
        check("busy_ign busy", {31'd0, busy}, 32'd1);
        repeat (22) @(posedge clk);
        #1;
        check("busy_ign done", {31'd0, done}, 32'd1);
        check("busy_ign lo", lo_out, 32'd14);
        check("busy_ign hi2", hi_out, 32'd2);
        @(posedge clk);
        #1;
        check("busy_ign idle", {31'd0, busy}, 32'd0);
        check("busy_ign no_mult", lo_out, 32'd14);

        // Reset mid-DIVU
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi", hi_out, 32'd0);
        check("midrst lo", lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", OP_MULTU, 32'd3, 32'd4, MUL_LAT);
        check("post_rst lo", lo_out, 32'd12);
        check("post_rst hi", hi_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
